// File: rtl/aes_pkg.sv
// Shared AES GF(2^8) helpers, column/byte indexing and the InvMixColumns FSM state type.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } inv_mc_state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul_09(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul_0b(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul_0d(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul_0e(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // Column c occupies bytes 4c..4c+3, row 0 in the most-significant byte.
  function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] c);
    int unsigned lsb;
    lsb = 32 * (3 - int'(c));
    return s[lsb +: 32];
  endfunction

  function automatic logic [127:0] set_col(input logic [127:0] s, input logic [1:0] c,
                                           input logic [31:0] v);
    logic [127:0] r;
    int unsigned  lsb;
    r = s;
    lsb = 32 * (3 - int'(c));
    r[lsb +: 32] = v;
    return r;
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] column, input int unsigned row);
    return column[(3 - row) * 8 +: 8];
  endfunction

endpackage

// File: rtl/aes_inv_mixcol_engine_if.sv
// Input/output valid-ready channels of the InvMixColumns engine.
interface aes_inv_mixcol_engine_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_inv_mixcol_column.sv
// Combinational InvMixColumns of one 32-bit column.
module aes_inv_mixcol_column
  import aes_pkg::*;
(
  input  logic [31:0] column,
  output logic [31:0] result
);

  logic [7:0] s0, s1, s2, s3;

  always_comb begin
    s0 = get_byte(column, 0);
    s1 = get_byte(column, 1);
    s2 = get_byte(column, 2);
    s3 = get_byte(column, 3);
    result = {
      gf_mul_0e(s0) ^ gf_mul_0b(s1) ^ gf_mul_0d(s2) ^ gf_mul_09(s3),
      gf_mul_09(s0) ^ gf_mul_0e(s1) ^ gf_mul_0b(s2) ^ gf_mul_0d(s3),
      gf_mul_0d(s0) ^ gf_mul_09(s1) ^ gf_mul_0e(s2) ^ gf_mul_0b(s3),
      gf_mul_0b(s0) ^ gf_mul_0d(s1) ^ gf_mul_09(s2) ^ gf_mul_0e(s3)
    };
  end

endmodule

// File: rtl/aes_inv_mixcol_engine.sv
// Column-serial AES InvMixColumns engine, COLS_PER_CYCLE columns per clock.
module aes_inv_mixcol_engine
  import aes_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  aes_inv_mixcol_engine_if.slave  bus,
  output logic                    busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // col wraps 3->0, so the exit decision uses the column of the final step.
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);

  inv_mc_state_t state, state_next;
  logic [127:0]  data_q, data_run;
  logic [1:0]    col_q;
  logic          last, accept;

  logic [COLS_PER_CYCLE-1:0][31:0] sel;
  logic [COLS_PER_CYCLE-1:0][31:0] mixed;

  always_comb begin
    for (int unsigned i = 0; i < COLS_PER_CYCLE; i++) begin
      sel[i] = get_col(data_q, col_q + 2'(i));
    end
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    aes_inv_mixcol_column u_col (
      .column (sel[g]),
      .result (mixed[g])
    );
  end

  always_comb begin
    data_run = data_q;
    for (int unsigned i = 0; i < COLS_PER_CYCLE; i++) begin
      data_run = set_col(data_run, col_q + 2'(i), mixed[i]);
    end
  end

  assign last   = (col_q == LAST_COL);
  assign accept = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (bus.in_valid) state_next = ST_RUN;
      ST_RUN:  if (last) state_next = ST_DONE;
      ST_DONE: if (bus.out_ready) state_next = bus.in_valid ? ST_RUN : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == ST_IDLE) | ((state == ST_DONE) & bus.out_ready);
    bus.out_valid = (state == ST_DONE);
    bus.out_data  = data_q;
    busy          = (state == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      col_q  <= '0;
    end else if (accept) begin
      data_q <= bus.in_data;
      col_q  <= '0;
    end else if (state == ST_RUN) begin
      data_q <= data_run;
      col_q  <= col_q + COL_STEP;
    end
  end

endmodule

// File: tb/tb_aes_inv_mixcol_engine.sv
// Directed self-checking bench for aes_inv_mixcol_engine at COLS_PER_CYCLE 1, 2 and 4.
module tb_aes_inv_mixcol_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [127:0] in_data;
  logic         out_ready;
  logic         busy1, busy2, busy4;
  int           errors = 0;
  int           checks = 0;

  aes_inv_mixcol_engine_if b1 ();
  aes_inv_mixcol_engine_if b2 ();
  aes_inv_mixcol_engine_if b4 ();

  assign b1.in_valid = in_valid;  assign b1.in_data = in_data;  assign b1.out_ready = out_ready;
  assign b2.in_valid = in_valid;  assign b2.in_data = in_data;  assign b2.out_ready = out_ready;
  assign b4.in_valid = in_valid;  assign b4.in_data = in_data;  assign b4.out_ready = out_ready;

  aes_inv_mixcol_engine #(.COLS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1), .busy(busy1));
  aes_inv_mixcol_engine #(.COLS_PER_CYCLE(2)) dut2 (.clk(clk), .rst(rst), .bus(b2), .busy(busy2));
  aes_inv_mixcol_engine #(.COLS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .bus(b4), .busy(busy4));

  always #5 clk = ~clk;

  localparam logic [127:0] V_SINGLE = {32'h9fdc589d, 96'h0};
  localparam logic [127:0] E_SINGLE = {32'hf20a225c, 96'h0};
  localparam logic [127:0] V_FULL   = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
  localparam logic [127:0] E_FULL   = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Caller is 1 time unit after a rising edge with all engines idle.
  task automatic xfer(input string tag, input logic [127:0] d, input logic [127:0] exp);
    int lat1, lat2, lat4;
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, " busy"}, 128'(busy1), 128'd1);
    lat1 = 0; lat2 = 0; lat4 = 0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (lat1 != 0) chk({tag, " hold1"}, b1.out_data, exp);
      if (b1.out_valid === 1'b1 && lat1 == 0) lat1 = n;
      if (b2.out_valid === 1'b1 && lat2 == 0) lat2 = n;
      if (b4.out_valid === 1'b1 && lat4 == 0) lat4 = n;
    end
    chk({tag, " lat1"}, 128'(lat1), 128'd4);
    chk({tag, " lat2"}, 128'(lat2), 128'd2);
    chk({tag, " lat4"}, 128'(lat4), 128'd1);
    chk({tag, " data1"}, b1.out_data, exp);
    chk({tag, " data2"}, b2.out_data, exp);
    chk({tag, " data4"}, b4.out_data, exp);
    chk({tag, " valid_held"}, 128'(b1.out_valid), 128'd1);
    chk({tag, " ready_wait"}, 128'(b1.in_ready), 128'd0);
    out_ready = 1'b1;
    #1;
    chk({tag, " ready_comb"}, 128'(b1.in_ready), 128'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " valid_drop"}, 128'({b1.out_valid, b2.out_valid, b4.out_valid}), 128'd0);
    chk({tag, " idle_ready"}, 128'(b1.in_ready), 128'd1);
  endtask

  initial begin
    logic [127:0] exp_cur;
    logic [127:0] exp_nxt;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst in_ready", 128'(b1.in_ready), 128'd1);
    chk("rst out_valid", 128'(b1.out_valid), 128'd0);
    chk("rst out_data", b1.out_data, 128'd0);
    chk("rst busy", 128'({busy1, busy2, busy4}), 128'd0);
    @(posedge clk); #1;

    xfer("single", V_SINGLE, E_SINGLE);
    xfer("full", V_FULL, E_FULL);
    xfer("fix01", {16{8'h01}}, {16{8'h01}});
    xfer("fixc6", {16{8'hc6}}, {16{8'hc6}});
    xfer("fix00", 128'd0, 128'd0);

    // Back-to-back with alternating blocks: a result every 5 cycles, in_ready only in DONE.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = V_FULL;
    exp_cur   = E_FULL;
    exp_nxt   = E_SINGLE;
    @(posedge clk); #1;
    for (int n = 1; n <= 19; n++) begin
      @(posedge clk); #1;
      chk("b2b valid", 128'(b1.out_valid), 128'((n % 5) == 4));
      chk("b2b ready", 128'(b1.in_ready), 128'((n % 5) == 4));
      if ((n % 5) == 4) begin
        chk("b2b data", b1.out_data, exp_cur);
        in_data = (exp_nxt == E_SINGLE) ? V_SINGLE : V_FULL;
        exp_cur = exp_nxt;
        exp_nxt = (exp_nxt == E_SINGLE) ? E_FULL : E_SINGLE;
      end
    end
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 out_ready = 1'b0;
    chk("b2b drained", 128'(b1.in_ready), 128'd1);

    // Reset during the second RUN cycle discards the transform.
    in_valid = 1'b1;
    in_data  = V_FULL;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid busy", 128'(busy1), 128'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid out_valid", 128'(b1.out_valid), 128'd0);
    chk("mid out_data", b1.out_data, 128'd0);
    chk("mid in_ready", 128'(b1.in_ready), 128'd1);
    chk("mid busy_clr", 128'(busy1), 128'd0);
    xfer("after_rst", V_FULL, E_FULL);

    // New input offered during RUN must be ignored.
    in_valid = 1'b1;
    in_data  = V_SINGLE;
    @(posedge clk); #1;
    in_data  = V_FULL;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("ign valid", 128'(b1.out_valid), 128'd1);
    chk("ign data1", b1.out_data, E_SINGLE);
    chk("ign data4", b4.out_data, E_SINGLE);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("ign release", 128'(b1.out_valid), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_inv_mixcol_engine.md
# aes_inv_mixcol_engine

Column-serial AES InvMixColumns engine for the decrypt path of the AES cypher design, the inverse of the encrypt-side MixColumns step. Accepts one 128-bit state over a valid/ready handshake, transforms it a configurable number of columns per cycle in GF(2^8), and presents the result on a valid/ready output port. Sits between the inverse round key-add and the next inverse round, inside the `tt_um_*` top-level wrapper.

## Interface
- `COLS_PER_CYCLE`, default 1: columns processed per clock; legal values 1, 2, 4 (elaboration error otherwise)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous reset, active-high
- `in_valid`  in  1  `in_data` is valid
- `in_ready`  out  1  engine accepts `in_data` this cycle
- `in_data`  in  128  input state; byte k = `in_data[127-8k -: 8]`; column c = bytes 4c..4c+3, row 0 in the most-significant byte
- `out_valid`  out  1  `out_data` holds a completed result
- `out_ready`  in  1  consumer takes `out_data` this cycle
- `out_data`  out  128  transformed state, same byte ordering
- `busy`  out  1  high in RUN

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `in_ready`=1. On `in_valid` latch `in_data` into the state register, clear column counter `col`, go to RUN.
- RUN: each cycle, replace columns `col`..`col+COLS_PER_CYCLE-1` in place with their InvMixColumns values and add `COLS_PER_CYCLE` to `col`. When the last column is written, go to DONE.
- DONE: `out_valid`=1, `out_data` = state register, held stable until accepted. On `out_ready`, go to IDLE. If `in_valid` is also high in that cycle, latch the new input and go directly to RUN (back-to-back).
- `in_ready` = IDLE | (DONE & `out_ready`). This is the only combinational path from input to output.
- Per column (s0..s3 → t0..t3): t0 = 0e·s0 ^ 0b·s1 ^ 0d·s2 ^ 09·s3; the coefficient row rotates right by one for each of t1, t2, t3.
- GF arithmetic: xtime(b) = {b[6:0],0} ^ (b[7] ? 8'h1b : 0); x2, x4, x8 by chained xtime; 09 = x8^x, 0b = x8^x2^x, 0d = x8^x4^x, 0e = x8^x4^x2. No multipliers and no lookup tables.
- `col` is 2 bits wide and wraps 3→0. This wrap is not a termination condition: exit RUN is decided by a last-step flag, which is correct for every COLS_PER_CYCLE.
- Reset, including mid-RUN: state → IDLE; `col`=0; state register=0; `out_valid`=0, `busy`=0, `out_data`=0, `in_ready`=1 in the cycle after reset deasserts. Any transform in progress is discarded and never emitted.
- `in_valid` while in RUN is ignored; no data is captured.

## Timing
- Latency from acceptance edge to `out_valid`: 4/`COLS_PER_CYCLE` cycles (4, 2, 1).
- Throughput with `out_ready` held high: one block per 4/`COLS_PER_CYCLE`+1 cycles.
- `out_data` is registered and stable for the whole time `out_valid` is high.
- `in_ready` depends combinationally on `out_ready` in DONE only.

## Structure
- Shared package `aes_pkg` holds: `xtime` function; `gf_mul_09/0b/0d/0e` functions; state enum `inv_mc_state_t`; byte/column index helper functions. The encrypt-side MixColumns reuses the same package.
- One combinational sub-module, `aes_inv_mixcol_column` (32-bit in, 32-bit out), instantiated `COLS_PER_CYCLE` times. Column selection is by a mux on `col`.

## Test plan
- Single column, all other columns zero, `in_data`[127:96]=9f dc 58 9d → after 4 cycles column 0 = f2 0a 22 5c, others 00; `out_valid` held while `out_ready`=0 for 5 cycles.
- Full state with columns 8e4da1bc, 9fdc589d, d5d5d7d6, 4d7ebdf8 → columns db135345, f20a225c, d4d4d4d5, 2d26314c; checked for each of COLS_PER_CYCLE 1, 2, 4 (latency 4, 2, 1).
- Fixed points: all-01 → all-01; all-c6 → all-c6; all-00 → all-00.
- Back-to-back: `in_valid` and `out_ready` high continuously → `in_ready` pulses in each DONE cycle, one result every 5 cycles (COLS=1), no idle gap.
- `rst` asserted in 2nd RUN cycle → next cycle IDLE, `out_valid`=0, `out_data`=0; the following block is correct.
- `in_valid` asserted with different data during RUN → ignored; the original result is emitted unchanged.
